// File: rtl/dfm_pkg.sv
// rtl/dfm_pkg.sv - shared types and defaults for the frequency-meter front end
package dfm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SYNC,
        SHIFT,
        RUN,
        STOP
    } gate_seq_state_t;

    localparam logic [31:0] DEFAULT_GATE_TIME_SHIFT = 32'd0;
    localparam logic [31:0] DEFAULT_SYNC_TIMEOUT    = 32'h00FF_FFFF;

    localparam logic GATE_MODE_STAGGER = 1'b0;
    localparam logic GATE_MODE_SIMUL   = 1'b1;

endpackage

// File: rtl/gate_next_ch.sv
// rtl/gate_next_ch.sv - combinational next-masked-channel finder
module gate_next_ch #(
    parameter int unsigned N_CH = 5
) (
    input  logic [N_CH-1:0] mask_i,
    input  logic [N_CH-1:0] en_i,
    output logic [N_CH-1:0] next_o,
    output logic            last_o
);

    localparam logic [N_CH-1:0] ONE = N_CH'(1);

    logic [N_CH-1:0] remain;

    // last_o: every masked channel is already enabled, nothing left to scan
    always_comb begin
        remain = mask_i & ~en_i;
        next_o = remain & (~remain + ONE);
        last_o = (remain == '0);
    end

endmodule

// File: rtl/gate_startup_seq.sv
// rtl/gate_startup_seq.sv - staggered/simultaneous gate-enable sequencer with sync handshake
module gate_startup_seq
    import dfm_pkg::*;
#(
    parameter int unsigned         N_CH         = 5,
    parameter int unsigned         CNT_W        = 32,
    parameter logic [CNT_W-1:0]    SYNC_TIMEOUT = CNT_W'(DEFAULT_SYNC_TIMEOUT)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    input  logic [CNT_W-1:0] shift_i,
    input  logic [N_CH-1:0]  ch_mask_i,
    input  logic [N_CH-1:0]  gate_sync_i,
    output logic [N_CH-1:0]  gate_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO_LAST = SYNC_TIMEOUT - CNT_ONE;

    gate_seq_state_t  state_q, state_d;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic [N_CH-1:0]  gate_en_q, gate_en_d;
    logic [CNT_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [N_CH-1:0]  scan_mask;
    logic [N_CH-1:0]  next_ch;
    logic             all_en;
    logic             sync_match;
    logic             sync_clear;

    // In IDLE gate_en_q is always zero, so the same finder yields the lowest requested channel
    assign scan_mask = (state_q == IDLE) ? ch_mask_i : mask_q;

    gate_next_ch #(
        .N_CH (N_CH)
    ) u_next_ch (
        .mask_i (scan_mask),
        .en_i   (gate_en_q),
        .next_o (next_ch),
        .last_o (all_en)
    );

    assign sync_match = ((gate_sync_i & mask_q) == gate_en_q);
    assign sync_clear = ((gate_sync_i & mask_q) == '0);

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        gate_en_d   = gate_en_q;
        shift_d     = shift_q;
        shift_cnt_d = shift_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        mode_d      = mode_q;
        done_d      = done_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (start_i && !stop_i && (ch_mask_i != '0)) begin
                    mode_d    = mode_i;
                    shift_d   = shift_i;
                    mask_d    = ch_mask_i;
                    err_d     = 1'b0;
                    gate_en_d = (mode_i == GATE_MODE_SIMUL) ? ch_mask_i : next_ch;
                    tmo_cnt_d = '0;
                    state_d   = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                if (stop_i) begin
                    gate_en_d = '0;
                    done_d    = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = STOP;
                end else if (sync_match) begin
                    if (all_en) begin
                        done_d  = 1'b1;
                        state_d = RUN;
                    end else if (shift_q == '0) begin
                        gate_en_d = gate_en_q | next_ch;
                        tmo_cnt_d = '0;
                    end else begin
                        shift_cnt_d = '0;
                        state_d     = SHIFT;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    gate_en_d = '0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_ONE;
                end
            end
            SHIFT: begin
                if (stop_i) begin
                    gate_en_d = '0;
                    done_d    = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = STOP;
                end else if (shift_cnt_q == shift_q - CNT_ONE) begin
                    gate_en_d = gate_en_q | next_ch;
                    tmo_cnt_d = '0;
                    state_d   = WAIT_SYNC;
                end else begin
                    shift_cnt_d = shift_cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (stop_i) begin
                    gate_en_d = '0;
                    done_d    = 1'b0;
                    tmo_cnt_d = '0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (sync_clear) begin
                    state_d = IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_ONE;
                end
            end
            default: begin
                gate_en_d = '0;
                done_d    = 1'b0;
                state_d   = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            gate_en_q   <= '0;
            shift_q     <= '0;
            shift_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            mode_q      <= GATE_MODE_STAGGER;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            gate_en_q   <= gate_en_d;
            shift_q     <= shift_d;
            shift_cnt_q <= shift_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign gate_en_o = gate_en_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_gate_startup_seq.sv
// tb/tb_gate_startup_seq.sv - self-checking bench for gate_startup_seq
module tb_gate_startup_seq;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic        stop_i;
    logic        mode_i;
    logic [31:0] shift_i;
    logic [4:0]  ch_mask_i;
    logic [4:0]  gate_sync_i;
    logic [4:0]  gate_en_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    logic        tie;
    logic [4:0]  sync_manual;

    int n_cmp = 0;
    int n_mis = 0;

    assign gate_sync_i = tie ? gate_en_o : sync_manual;

    gate_startup_seq #(
        .N_CH         (5),
        .CNT_W        (32),
        .SYNC_TIMEOUT (32'd16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .mode_i      (mode_i),
        .shift_i     (shift_i),
        .ch_mask_i   (ch_mask_i),
        .gate_sync_i (gate_sync_i),
        .gate_en_o   (gate_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // k-th masked channel (ascending) turns on k*(S+1) edges after start when sync echoes
    function automatic logic [4:0] model_en(input logic m, input logic [4:0] msk,
                                            input int s, input int k);
        logic [4:0] res;
        int j;
        res = '0;
        j   = 0;
        for (int i = 0; i < 5; i++) begin
            if (msk[i]) begin
                if (m || (j * (s + 1) <= k)) res[i] = 1'b1;
                j++;
            end
        end
        return res;
    endfunction

    task automatic run_seq(input logic m, input logic [4:0] msk, input int s);
        int k_done;
        k_done = m ? 1 : ($countones(msk) - 1) * (s + 1) + 1;
        tie       = 1'b1;
        mode_i    = m;
        ch_mask_i = msk;
        shift_i   = 32'(s);
        start_i   = 1'b1;
        tick;
        start_i   = 1'b0;
        ch_mask_i = 5'($urandom);
        shift_i   = $urandom;
        for (int k = 0; k <= k_done + 2; k++) begin
            if (k > 0) tick;
            chk("seq_en",   32'(gate_en_o), 32'(model_en(m, msk, s, k)));
            chk("seq_done", 32'(done_o),    32'(k >= k_done));
            chk("seq_busy", 32'(busy_o),    32'd1);
            chk("seq_err",  32'(err_o),     32'd0);
        end
        stop_i = 1'b1;
        tick;
        stop_i = 1'b0;
        chk("stop_en",   32'(gate_en_o), 32'd0);
        chk("stop_done", 32'(done_o),    32'd0);
        chk("stop_busy", 32'(busy_o),    32'd1);
        tick;
        chk("idle_busy", 32'(busy_o),    32'd0);
    endtask

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        stop_i      = 1'b0;
        mode_i      = 1'b0;
        shift_i     = '0;
        ch_mask_i   = '0;
        tie         = 1'b1;
        sync_manual = '0;
        tick;
        tick;
        chk("rst_en",   32'(gate_en_o), 32'd0);
        chk("rst_busy", 32'(busy_o),    32'd0);
        chk("rst_done", 32'(done_o),    32'd0);
        chk("rst_err",  32'(err_o),     32'd0);
        rst_i = 1'b0;
        tick;

        run_seq(1'b0, 5'b11111, 3);
        run_seq(1'b1, 5'b10101, 0);
        run_seq(1'b0, 5'b10010, 0);
        for (int t = 0; t < 8; t++) begin
            run_seq(1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), $urandom_range(0, 4));
        end

        // empty mask and start+stop together are both ignored
        ch_mask_i = 5'b00000;
        start_i   = 1'b1;
        tick;
        chk("zero_mask_busy", 32'(busy_o), 32'd0);
        ch_mask_i = 5'b11111;
        stop_i    = 1'b1;
        tick;
        start_i   = 1'b0;
        stop_i    = 1'b0;
        chk("startstop_en",   32'(gate_en_o), 32'd0);
        chk("startstop_busy", 32'(busy_o),    32'd0);
        tick;
        chk("startstop_en2",  32'(gate_en_o), 32'd0);

        // start while in RUN has no effect
        mode_i    = 1'b1;
        ch_mask_i = 5'b01011;
        start_i   = 1'b1;
        tick;
        start_i   = 1'b0;
        tick;
        chk("run_done", 32'(done_o), 32'd1);
        mode_i    = 1'b0;
        ch_mask_i = 5'b10100;
        start_i   = 1'b1;
        tick;
        start_i   = 1'b0;
        chk("run_restart_en",   32'(gate_en_o), 32'h0B);
        chk("run_restart_done", 32'(done_o),    32'd1);
        stop_i = 1'b1;
        tick;
        stop_i = 1'b0;
        tick;
        chk("run_stop_busy", 32'(busy_o), 32'd0);

        // stop during SHIFT aborts before done
        mode_i    = 1'b0;
        ch_mask_i = 5'b00011;
        shift_i   = 32'd5;
        start_i   = 1'b1;
        tick;
        start_i   = 1'b0;
        chk("abort_first_en", 32'(gate_en_o), 32'h01);
        tick;
        stop_i = 1'b1;
        tick;
        stop_i = 1'b0;
        chk("abort_en",   32'(gate_en_o), 32'd0);
        chk("abort_busy", 32'(busy_o),    32'd1);
        tick;
        chk("abort_idle", 32'(busy_o),    32'd0);
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("abort_done", 32'(done_o),    32'd0);
            chk("abort_en2",  32'(gate_en_o), 32'd0);
        end

        // sync timeout after 16 unmatched wait cycles
        tie         = 1'b0;
        sync_manual = 5'b00000;
        ch_mask_i   = 5'b00111;
        shift_i     = 32'd0;
        start_i     = 1'b1;
        tick;
        start_i     = 1'b0;
        for (int k = 1; k < 16; k++) begin
            tick;
            chk("tmo_wait_en",  32'(gate_en_o), 32'h01);
            chk("tmo_wait_err", 32'(err_o),     32'd0);
        end
        tick;
        chk("tmo_en",   32'(gate_en_o), 32'd0);
        chk("tmo_err",  32'(err_o),     32'd1);
        chk("tmo_busy", 32'(busy_o),    32'd0);
        tick;
        chk("tmo_err_sticky", 32'(err_o), 32'd1);
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        chk("tmo_clear_err", 32'(err_o),     32'd0);
        chk("tmo_restart",   32'(gate_en_o), 32'h01);

        // async reset mid-WAIT_SYNC, between edges
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_en",   32'(gate_en_o), 32'd0);
        chk("arst_busy", 32'(busy_o),    32'd0);
        chk("arst_err",  32'(err_o),     32'd0);
        chk("arst_done", 32'(done_o),    32'd0);
        tick;
        rst_i = 1'b0;
        tie   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("arst_idle_busy", 32'(busy_o),    32'd0);
            chk("arst_idle_en",   32'(gate_en_o), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/gate_startup_seq.md
Name: gate_startup_seq

Overview:
Parametrised gate-enable sequencer for the multi-channel frequency-meter front end, feeding the per-channel gate counters.
- Enables N_CH measurement gates in either of two modes:
  - staggered: ascending channel index, one programmable time shift between channels;
  - simultaneous: all selected channels at once.
- Waits for each channel's gate_sync acknowledge before advancing; unacknowledged channels time out.
- Supports a per-channel mask, a run/stop lifecycle, and busy/done/error status for the AXI register block.

Parameters:
N_CH, 5, number of gate channels (1..32)
CNT_W, 32, width of shift and timeout counters
SYNC_TIMEOUT, 32'h00FF_FFFF, max cycles waiting for a sync match before error

Ports:
clk_i  in  1  clock
rst_i  in  1  reset: one clock; reset is asynchronous and active-high
start_i  in  1  single-cycle start request
stop_i  in  1  single-cycle stop/abort request
mode_i  in  1  0 = staggered, 1 = simultaneous; latched on accepted start
shift_i  in  CNT_W  inter-channel time shift S in cycles; latched on accepted start
ch_mask_i  in  N_CH  channels to enable; latched on accepted start
gate_sync_i  in  N_CH  per-channel gate-active acknowledge from gate counters
gate_en_o  out  N_CH  per-channel gate enable (registered)
busy_o  out  1  state != IDLE
done_o  out  1  all masked channels enabled and acknowledged (state RUN)
err_o  out  1  sticky sync-timeout flag, cleared on next accepted start

Behaviour:
- Reset (async, rst_i=1): state IDLE; gate_en_o=0, busy_o=0, done_o=0, err_o=0; all latches and counters 0. Reset mid-sequence drops all enables immediately.
- All outputs are registered, with no combinational input-to-output path.
- IDLE:
  - start_i=1, stop_i=0, ch_mask_i!=0 → accept. Latch mode/shift/mask, clear err_o.
  - On the accepting edge T, set gate_en_o: staggered = lowest masked bit; simultaneous = full mask. Enter WAIT_SYNC; gate_en_o is visible after edge T.
  - start_i with ch_mask_i==0 is ignored. start_i together with stop_i: stop wins, start ignored.
- WAIT_SYNC:
  - Match condition: (gate_sync_i & mask_r) == gate_en_o, sampled each edge.
  - Timeout counter restarts at 0 on entry and increments each cycle without a match. When it reaches SYNC_TIMEOUT: gate_en_o←0, err_o←1, next state IDLE.
  - On a match at edge E:
    - all masked channels enabled → RUN; done_o=1 after E.
    - else, S==0 → next masked bit set at E (visible after E).
    - else → SHIFT with counter 0.
- SHIFT:
  - Counts S cycles. At the edge where the count reaches S-1, set the next higher masked bit and return to WAIT_SYNC.
  - Net effect: the next enable appears after edge E+S, so channel spacing is S+1 edges when sync echoes within a cycle.
  - Unmasked channel indices are skipped with no shift spent on them.
- RUN: gate_en_o holds; done_o=1; start_i ignored. stop_i → STOP.
- STOP:
  - gate_en_o←0 on the entry edge; done_o←0.
  - Wait until (gate_sync_i & mask_r)==0, then IDLE.
  - Same timeout rule as WAIT_SYNC: on expiry, err_o←1 and next state IDLE.
- stop_i in WAIT_SYNC or SHIFT → STOP (abort), with the same clear/wait rule.
- start_i outside IDLE is always ignored.
- Counter width: SHIFT and timeout counters are CNT_W bits and never wrap. SYNC_TIMEOUT ≤ 2^CNT_W-1; S up to 2^CNT_W-1 is legal.
- gate_en_o bits outside mask_r are always 0.

Decomposition:
- Shared package dfm_pkg:
  - gate_seq_state_t enum: IDLE, WAIT_SYNC, SHIFT, RUN, STOP;
  - DEFAULT_GATE_TIME_SHIFT;
  - DEFAULT_SYNC_TIMEOUT;
  - mode encodings GATE_MODE_STAGGER = 0, GATE_MODE_SIMUL = 1.
- One natural sub-module, gate_next_ch: combinational next-masked-channel finder. Given mask_r and the current enables, it outputs the one-hot next bit and a last flag. It is reused by other channel-scan blocks.
- The FSM and both counters live in gate_startup_seq.

Test Plan:
- Staggered, N_CH=5, mask=5'b11111, S=3, gate_sync_i tied to gate_en_o (1-cycle echo), start at edge T → gate_en_o = 00001@T, 00011@T+4, 00111@T+8, 01111@T+12, 11111@T+16; done_o=1 after T+17.
- Simultaneous, mask=5'b10101, sync echoed → gate_en_o=10101 after T, done_o=1 after T+1; then stop_i → gate_en_o=0 next edge, busy_o=0 one edge after sync drops.
- Mask skip: staggered, mask=5'b10010, S=0, echo → 00010@T, 10010@T+1; bits 0, 2, 3 stay 0 throughout.
- Timeout: SYNC_TIMEOUT=16, gate_sync_i held 0 → after 16 wait cycles gate_en_o=0, err_o=1, state IDLE. A following start clears err_o.
- Abort/priority:
  - stop_i during SHIFT → gate_en_o=0 next edge, done_o never asserts.
  - start_i+stop_i together in IDLE → no enables.
  - start_i in RUN → no effect.
- Async reset asserted mid-WAIT_SYNC (between clock edges) → gate_en_o, busy_o, err_o all 0 without a clock edge; after release, idle until start_i.
